velocity_frame_builder: RTL and testbench

Upstream stage of the bot velocity writer. Collects per-bot velocity commands (signed Q4.11) from the motion controller over a valid/ready stream and clamps each to ±VMAX. Assembles a three-bot frame, then presents it on the writer's six 16-bit velocity inputs. It raises write_check and holds the frame stable for HOLD_CYCLES so the writer's delayed file handshake samples settled data.

---
 rtl/vel_pkg.sv | 24 ++
 rtl/vel_clamp.sv | 30 +++
 rtl/velocity_frame_builder.sv | 173 +++++++++++++++++
 tb/tb_velocity_frame_builder.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vel_pkg.sv
// Shared types and constants for the velocity frame builder: word format,
// bot addressing, FSM states and a Q4.11 conversion helper.
package vel_pkg;

  localparam int DATA_W   = 16;
  localparam int FRAC_W   = 11;
  localparam int VMAX_DEF = 205;
  localparam int NUM_BOTS = 3;

  typedef logic [1:0] bot_id_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Converts a velocity in thousandths of a unit to a Q4.11 word (truncating).
  function automatic logic [DATA_W-1:0] to_q411(input int milli);
    return DATA_W'((milli * (1 << FRAC_W)) / 1000);
  endfunction

endpackage

// File: rtl/vel_clamp.sv
// Combinational signed saturator: limits v to [-vmax, +vmax] and flags
// when the limit was applied.
module vel_clamp #(
  parameter int DATA_W = vel_pkg::DATA_W
) (
  input  logic signed [DATA_W-1:0] v,
  input  logic signed [DATA_W-1:0] vmax,
  output logic signed [DATA_W-1:0] v_out,
  output logic                     clamped
);

  logic signed [DATA_W-1:0] vmin;

  assign vmin = -vmax;

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    v_out   = v;
    clamped = 1'b0;
    if (v > vmax) begin
      v_out   = vmax;
      clamped = 1'b1;
    end else if (v < vmin) begin
      v_out   = vmin;
      clamped = 1'b1;
    end
  end

endmodule

// File: rtl/velocity_frame_builder.sv
// Collects clamped per-bot velocity updates into a three-bot frame and
// presents it to the velocity writer with a held write_check strobe.
module velocity_frame_builder
  import vel_pkg::*;
#(
  parameter int DATA_W      = vel_pkg::DATA_W,
  parameter int VMAX        = vel_pkg::VMAX_DEF,
  parameter int HOLD_CYCLES = 32,
  parameter int TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  bot_id_t           in_bot_id,
  input  logic [DATA_W-1:0] in_vx,
  input  logic [DATA_W-1:0] in_vy,
  output logic [DATA_W-1:0] vx1_bin,
  output logic [DATA_W-1:0] vy1_bin,
  output logic [DATA_W-1:0] vx2_bin,
  output logic [DATA_W-1:0] vy2_bin,
  output logic [DATA_W-1:0] vx3_bin,
  output logic [DATA_W-1:0] vy3_bin,
  output logic              write_check,
  output logic [2:0]        frame_mask,
  output logic              sat_flag,
  output logic              id_err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [TW-1:0]            TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0]            HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic signed [DATA_W-1:0] VMAX_W     = DATA_W'(VMAX);

  state_t                   state;
  logic [NUM_BOTS-1:0]      mask;
  logic [NUM_BOTS-1:0]      mask_next;
  logic                     sat;
  logic [TW-1:0]            timer;
  logic [HW-1:0]            hold_cnt;
  logic signed [DATA_W-1:0] stage_vx [NUM_BOTS];
  logic signed [DATA_W-1:0] stage_vy [NUM_BOTS];
  logic signed [DATA_W-1:0] out_vx   [NUM_BOTS];
  logic signed [DATA_W-1:0] out_vy   [NUM_BOTS];
  logic signed [DATA_W-1:0] vx_c;
  logic signed [DATA_W-1:0] vy_c;
  logic                     vx_sat;
  logic                     vy_sat;
  logic                     accept;
  logic                     legal;
  logic                     take;

  vel_clamp #(.DATA_W(DATA_W)) u_clamp_x (
    .v       (in_vx),
    .vmax    (VMAX_W),
    .v_out   (vx_c),
    .clamped (vx_sat)
  );

  vel_clamp #(.DATA_W(DATA_W)) u_clamp_y (
    .v       (in_vy),
    .vmax    (VMAX_W),
    .v_out   (vy_c),
    .clamped (vy_sat)
  );

  // Ready is a pure function of state so the upstream never sees a loop
  // through in_valid.
  assign in_ready = (state == IDLE) || (state == COLLECT);
  assign accept   = in_valid && in_ready;
  assign legal    = (in_bot_id < bot_id_t'(NUM_BOTS));
  assign take     = accept && legal;

  always_comb begin
    mask_next = mask;
    for (int b = 0; b < NUM_BOTS; b++) begin
      if (take && (in_bot_id == bot_id_t'(b))) mask_next[b] = 1'b1;
    end
  end

  // NOTE: all state, including the staging and output arrays, updates with
  // non-blocking assignments so every read in this block sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mask        <= '0;
      sat         <= 1'b0;
      timer       <= '0;
      hold_cnt    <= '0;
      write_check <= 1'b0;
      frame_mask  <= '0;
      sat_flag    <= 1'b0;
      id_err      <= 1'b0;
      // NOTE: the small staging/output arrays are reset explicitly because a
      // reset must drop the staged frame and return the writer inputs to 0.
      for (int b = 0; b < NUM_BOTS; b++) begin
        stage_vx[b] <= '0;
        stage_vy[b] <= '0;
        out_vx[b]   <= '0;
        out_vy[b]   <= '0;
      end
    end else begin
      id_err <= accept && !legal;

      for (int b = 0; b < NUM_BOTS; b++) begin
        if (take && (in_bot_id == bot_id_t'(b))) begin
          stage_vx[b] <= vx_c;
          stage_vy[b] <= vy_c;
        end
      end

      case (state)
        IDLE: begin
          if (take) begin
            mask  <= mask_next;
            sat   <= vx_sat | vy_sat;
            timer <= '0;
            state <= COLLECT;
          end
        end

        COLLECT: begin
          mask <= mask_next;
          if (take) sat <= sat | vx_sat | vy_sat;
          // A full mask and an expiring timer on the same edge still give
          // exactly one commit.
          if ((&mask_next) || (timer == TIMER_LAST)) begin
            state <= COMMIT;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        COMMIT: begin
          for (int b = 0; b < NUM_BOTS; b++) begin
            if (mask[b]) begin
              out_vx[b] <= stage_vx[b];
              out_vy[b] <= stage_vy[b];
            end
          end
          frame_mask  <= mask;
          sat_flag    <= sat;
          write_check <= 1'b1;
          hold_cnt    <= '0;
          state       <= HOLD;
        end

        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            write_check <= 1'b0;
            mask        <= '0;
            sat         <= 1'b0;
            timer       <= '0;
            state       <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign vx1_bin = out_vx[0];
  assign vy1_bin = out_vy[0];
  assign vx2_bin = out_vx[1];
  assign vy2_bin = out_vy[1];
  assign vx3_bin = out_vx[2];
  assign vy3_bin = out_vy[2];

endmodule

// File: tb/tb_velocity_frame_builder.sv
// Scoreboard bench for velocity_frame_builder: a frame-level reference model
// predicts each committed frame; a monitor checks it when write_check rises.
module tb_velocity_frame_builder;

  localparam int DW   = 16;
  localparam int VMAX = 205;
  localparam int HOLD = 32;
  localparam int TMO  = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_bot_id = '0;
  logic [DW-1:0] in_vx = '0;
  logic [DW-1:0] in_vy = '0;
  logic [DW-1:0] vx1_bin, vy1_bin, vx2_bin, vy2_bin, vx3_bin, vy3_bin;
  logic          write_check;
  logic [2:0]    frame_mask;
  logic          sat_flag;
  logic          id_err;

  velocity_frame_builder #(
    .DATA_W(DW), .VMAX(VMAX), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_bot_id(in_bot_id),
    .in_vx(in_vx), .in_vy(in_vy),
    .vx1_bin(vx1_bin), .vy1_bin(vy1_bin), .vx2_bin(vx2_bin),
    .vy2_bin(vy2_bin), .vx3_bin(vx3_bin), .vy3_bin(vy3_bin),
    .write_check(write_check), .frame_mask(frame_mask),
    .sat_flag(sat_flag), .id_err(id_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0][DW-1:0] vx;
    logic [2:0][DW-1:0] vy;
    logic [2:0]         mask;
    logic               sat;
    logic [31:0]        rise;
  } frame_t;

  frame_t exp_q[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     exp_id_err = 0;
  int     id_err_seen = 0;
  int     commits = 0;
  bit     mon_en = 1'b0;

  // Reference model: staged window and the writer-visible frame.
  int     m_vx[3], m_vy[3], cur_vx[3], cur_vy[3];
  bit [2:0] m_mask = '0;
  bit     m_sat = 1'b0;
  int     first_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp_ref(input logic [DW-1:0] raw);
    int v;
    v = int'($signed(raw));
    if (v > VMAX) return VMAX;
    if (v < -VMAX) return -VMAX;
    return v;
  endfunction

  task automatic model_commit(input int rise);
    frame_t f;
    for (int b = 0; b < 3; b++) begin
      if (m_mask[b]) begin
        cur_vx[b] = m_vx[b];
        cur_vy[b] = m_vy[b];
      end
      f.vx[b] = DW'(cur_vx[b]);
      f.vy[b] = DW'(cur_vy[b]);
    end
    f.mask = m_mask;
    f.sat  = m_sat;
    f.rise = 32'(rise);
    exp_q.push_back(f);
    m_mask = '0;
    m_sat  = 1'b0;
    commits++;
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_vx[b] = 0; m_vy[b] = 0; cur_vx[b] = 0; cur_vy[b] = 0;
    end
    m_mask = '0;
    m_sat  = 1'b0;
  endtask

  // Presents one beat (in_valid stays high afterwards) and updates the model
  // on the edge where it is actually accepted.
  task automatic send(input logic [1:0] id, input logic [DW-1:0] vx, input logic [DW-1:0] vy);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_bot_id = id;
    in_vx     = vx;
    in_vy     = vy;
    while (!in_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("send_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (id == 2'd3) begin
      exp_id_err++;
    end else begin
      if (m_mask == 3'b000) first_cyc = cyc;
      m_vx[id] = clamp_ref(vx);
      m_vy[id] = clamp_ref(vy);
      if (m_vx[id] != int'($signed(vx)) || m_vy[id] != int'($signed(vy))) m_sat = 1'b1;
      m_mask[id] = 1'b1;
      if (m_mask == 3'b111) model_commit(cyc + 1);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done();
    int budget;
    budget = 3000;
    while (!write_check && budget > 0) begin @(negedge clk); budget--; end
    while (write_check && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) check("frame_wait_timeout", 32'(write_check), 32'd0);
  endtask

  function automatic logic [DW-1:0] pick_v();
    case ($urandom_range(0, 6))
      0:       return DW'($urandom);
      1:       return DW'($urandom_range(0, 2 * VMAX)) - DW'(VMAX);
      2:       return 16'h8000;
      3:       return DW'(VMAX + 1);
      4:       return -DW'(VMAX + 1);
      5:       return vel_pkg::to_q411(int'($urandom_range(0, 120)));
      default: return -DW'(VMAX);
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops one expected frame per write_check rise.
  initial begin
    frame_t f;
    bit     prev_wc;
    int     hold_len;
    prev_wc  = 1'b0;
    hold_len = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_wc  = 1'b0;
        hold_len = 0;
      end else begin
        if (write_check && !prev_wc) begin
          hold_len = 1;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
          end else begin
            f = exp_q.pop_front();
            check("rise_cycle", 32'(cyc), f.rise);
            check("vx1", 32'(vx1_bin), 32'(f.vx[0]));
            check("vy1", 32'(vy1_bin), 32'(f.vy[0]));
            check("vx2", 32'(vx2_bin), 32'(f.vx[1]));
            check("vy2", 32'(vy2_bin), 32'(f.vy[1]));
            check("vx3", 32'(vx3_bin), 32'(f.vx[2]));
            check("vy3", 32'(vy3_bin), 32'(f.vy[2]));
            check("frame_mask", 32'(frame_mask), 32'(f.mask));
            check("sat_flag", 32'(sat_flag), 32'(f.sat));
          end
        end else if (write_check) begin
          hold_len++;
        end else if (prev_wc) begin
          check("hold_len", 32'(hold_len), 32'(HOLD));
        end
        if (write_check) check("ready_low_in_hold", 32'(in_ready), 32'd0);
        if (id_err) id_err_seen++;
        prev_wc = write_check;
      end
    end
  end

  task automatic check_outs_zero(input string tag);
    check({tag, "_wc"},   32'(write_check), 32'd0);
    check({tag, "_vx1"},  32'(vx1_bin), 32'd0);
    check({tag, "_vy1"},  32'(vy1_bin), 32'd0);
    check({tag, "_vx2"},  32'(vx2_bin), 32'd0);
    check({tag, "_vy2"},  32'(vy2_bin), 32'd0);
    check({tag, "_vx3"},  32'(vx3_bin), 32'd0);
    check({tag, "_vy3"},  32'(vy3_bin), 32'd0);
    check({tag, "_mask"}, 32'(frame_mask), 32'd0);
    check({tag, "_sat"},  32'(sat_flag), 32'd0);
  endtask

  initial begin
    int start_commits;
    int beats;
    int waited;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs_zero("reset");
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_id_err", 32'(id_err), 32'd0);
    mon_en = 1'b1;

    // Basic three-bot frame on consecutive cycles.
    send(2'd0, 16'h007B, 16'h00A4);
    send(2'd1, 16'h0014, 16'h0014);
    send(2'd2, 16'h007B, 16'h00A4);
    idle(0);
    wait_done();

    // Clamp on bot0 in both directions.
    send(2'd0, 16'h0200, 16'hFE00);
    send(2'd1, 16'h0001, 16'h0002);
    send(2'd2, 16'h0003, 16'h0004);
    idle(0);
    wait_done();
    check("clamp_vx1", 32'(vx1_bin), 32'h00CD);
    check("clamp_vy1", 32'(vy1_bin), 32'hFF33);
    check("clamp_sat", 32'(sat_flag), 32'd1);

    // Partial frame forced out by the timeout.
    send(2'd1, 16'h0050, 16'h0060);
    idle(0);
    model_commit(first_cyc + TMO + 1);
    wait_done();
    check("partial_mask", 32'(frame_mask), 32'b010);
    check("partial_vx2", 32'(vx2_bin), 32'h0050);
    check("partial_vx1_kept", 32'(vx1_bin), 32'h00CD);

    // Overwrite and an illegal bot id.
    send(2'd0, 16'h0010, 16'h0011);
    send(2'd0, 16'h0020, 16'h0021);
    send(2'd3, 16'h0099, 16'h0099);
    send(2'd1, 16'h0030, 16'h0031);
    send(2'd2, 16'h0040, 16'h0041);
    idle(0);
    wait_done();
    check("overwrite_vx1", 32'(vx1_bin), 32'h0020);

    // Illegal id while idle must not open a window.
    send(2'd3, 16'h0001, 16'h0001);
    idle(2);
    check("id3_idle_ready", 32'(in_ready), 32'd1);

    // Randomized frames, gaps between beats.
    for (int fr = 0; fr < 16; fr++) begin
      start_commits = commits;
      beats = 0;
      while (commits == start_commits && beats < 200) begin
        send(2'($urandom_range(0, 3)), pick_v(), pick_v());
        beats++;
        if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
      end
    end
    idle(0);
    wait_done();

    // Back-to-back frames with in_valid held high throughout.
    for (int fr = 0; fr < 4; fr++) begin
      send(2'd2, pick_v(), pick_v());
      send(2'd0, pick_v(), pick_v());
      send(2'd1, pick_v(), pick_v());
    end
    idle(0);
    wait_done();

    // Reset ten cycles into HOLD.
    send(2'd0, 16'h0005, 16'h0006);
    send(2'd1, 16'h0007, 16'h0008);
    send(2'd2, 16'h0009, 16'h000A);
    idle(0);
    waited = 0;
    while (!write_check && waited < 100) begin @(negedge clk); waited++; end
    check("pre_reset_wc", 32'(write_check), 32'd1);
    repeat (10) @(negedge clk);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_outs_zero("midhold_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 32'(in_ready), 32'd1);
    mon_en = 1'b1;

    // One more frame after reset to confirm a clean restart.
    send(2'd1, 16'h0011, 16'h0012);
    send(2'd2, 16'h0013, 16'h0014);
    send(2'd0, 16'h0015, 16'h0016);
    idle(0);
    wait_done();
    idle(3);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("id_err_pulses", 32'(id_err_seen), 32'(exp_id_err));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
